wb_buffer: RTL
==============

// Module: wb_buffer
// PURPOSE
//  4-lane writeback buffer directly upstream of the 4-write/8-read integer register file.
//  Collects up to 4 execution results per cycle and queues them in a FIFO.
//  Drains up to 4 entries per cycle onto the regfile write ports in program order.
//  Guarantees at most one write per register address per cycle, so regfile port priority never decides the result.
// PARAMETERS
//  DEPTH  8   FIFO entries; power of two, >=4
//  AW     5   register address width
//  DW     32  data width
// PORTS
//  i_clk          in   1      clock, rising edge
//  i_rst_n        in   1      asynchronous active-low reset
//  i_valid        in   4      per-lane result valid; lane k = bit k
//  i_addr0..3     in   AW     destination register, lane 0..3
//  i_data0..3     in   DW     result data, lane 0..3
//  o_ready        out  1      buffer accepts all valid lanes this cycle
//  i_hold         in   1      1 = suppress draining this cycle
//  o_we0..3       out  1      regfile write enable, port 0..3
//  o_waddr0..3    out  AW     regfile write address, port 0..3
//  o_wdata0..3    out  DW     regfile write data, port 0..3
//  o_count        out  $clog2(DEPTH)+1   occupied entries
//  o_empty        out  1      o_count==0
// BEHAVIOUR
//  - Reset (async, any time):
//    - head=tail=count=0; contents discarded.
//    - o_we*=0, o_waddr*/o_wdata*=0, o_empty=1, o_ready=1.
//  - o_ready = (DEPTH-count)>=4. Combinational from registered count only; no dependence on i_valid.
//  - Enqueue: at posedge when o_ready=1.
//    - Lanes with i_valid=1 and addr!=0 are compacted in lane order 0..3 into tail..tail+n-1.
//    - Lanes with addr==0 are silently dropped.
//    - With o_ready=0 nothing is taken; the producer holds i_valid/addr/data until o_ready=1.
//  - Drain group: combinational from registered storage.
//    - With i_hold=0, take oldest entries head, head+1, ... up to min(4,count).
//    - Stop before the first entry whose addr equals an earlier entry in the group.
//    - Group entry j drives port j (o_we j=1); ports beyond the group have o_we=0.
//    - With i_hold=1, all o_we=0.
//    - head advances by group size at posedge; the regfile always accepts.
//  - Latency: result enqueued at edge N appears on o_we* no earlier than the cycle after edge N.
//  - Same-cycle enqueue and drain are legal: count_next = count + n_enq - n_deq.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; a group may straddle the wrap.
//  - Per-address write order equals enqueue order: FIFO order plus duplicate stop.
//  - Overflow is impossible by construction (o_ready gating); underflow is impossible (group<=count).
// CONFIGURATION
//  WB_FWD_EN defined:
//    - Adds i_faddr0/1 (AW) and o_fhit0/1 (1), o_fdata0/1 (DW).
//    - Combinational search of occupied entries.
//    - Hit returns the youngest matching entry's data.
//    - faddr==0 never hits.
//    - Entries draining this cycle still count as hits.
//  WB_FWD_EN undefined: those ports and the search logic are absent; other behaviour is identical.
// STRUCTURE
//  - Package wb_pkg:
//    - WB_LANES=4.
//    - typedef wb_entry_t {addr[AW], data[DW]}.
//    - Pointer/count width functions.
//  - Sub-module wb_drain_sel:
//    - Combinational; takes the 4 oldest entries plus count/hold.
//    - Returns per-port enable mask and n_deq, applying the duplicate-address stop.
//  - Top module: storage, head/tail/count registers, lane compaction, optional forward search.
// TESTING
//  - Reset: fill 6 entries with i_hold=1, pull i_rst_n low mid-cycle -> o_we*=0, o_count=0, o_ready=1, o_empty=1 immediately.
//  - 4 lanes addr 1,2,3,4 data A,B,C,D with i_hold=0 -> next cycle o_we=1111, ports 0..3 carry 1/A..4/D; following cycle o_we=0000.
//  - Lanes addr 1,0,3,4 -> o_count=3; drain o_waddr0/1/2 = 1,3,4, o_we3=0.
//  - Lanes addr 5/0x1, 5/0x2, 6/0x3 -> cycle 1: port0 5<=0x1 only; cycle 2: port0 5<=0x2, port1 6<=0x3.
//  - DEPTH=8, i_hold=1, enqueue 4 then 1 -> o_ready=0 at count 5; hold valid 3 cycles, drop i_hold -> drain 4, o_ready=1, pending lanes enqueued.
//  - WB_FWD_EN, i_hold=1, enqueue addr 7/0x11 then 7/0x22; i_faddr0=7 -> o_fhit0=1, o_fdata0=0x22; i_faddr1=0 -> o_fhit1=0.

Source files
------------

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
//   Shared constants, types and sizing helpers for the writeback buffer.
//
//   Contents:
//     WB_LANES     number of producer lanes and of regfile write ports (4)
//     WB_AW/WB_DW  default register address / data widths
//     wb_entry_t   one queued result {addr, data} at the default widths
//     wb_ptr_w()   head/tail pointer width for a given depth
//     wb_cnt_w()   occupancy counter width for a given depth (holds 0..DEPTH)
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_LANES = 4;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;

  // Width of the drain/enqueue group size (0..WB_LANES).
  localparam int WB_NW    = $clog2(WB_LANES) + 1;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  function automatic int wb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int wb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_drain_sel.sv
// -----------------------------------------------------------------------------
// wb_drain_sel
//   Chooses which of the four oldest buffer entries drain this cycle.
//   Purely combinational.
//
//   The group is the longest run of oldest entries that
//     - is no longer than min(WB_LANES, count),
//     - contains no register address twice.
//   Stopping at the first repeated address (rather than skipping it) keeps
//   per-address write order equal to enqueue order and means the regfile
//   never sees two writes to one register in a cycle.
//
//   Ports:
//     addr   [WB_LANES] in  addresses at head, head+1, head+2, head+3
//     count  CW         in  occupied entries (registered)
//     hold   1          in  1 = drain nothing this cycle
//     en     WB_LANES   out per-port write enable; always a contiguous low run
//     n_deq  WB_NW      out number of entries leaving (popcount of en)
// -----------------------------------------------------------------------------
module wb_drain_sel
  import wb_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int CW = 4
) (
  input  logic [AW-1:0]       addr [WB_LANES],
  input  logic [CW-1:0]       count,
  input  logic                hold,
  output logic [WB_LANES-1:0] en,
  output logic [WB_NW-1:0]    n_deq
);

  // avail[j]: slot j of the peek window holds a real entry.
  // uniq[j]:  slot j's address differs from every older slot in the window.
  logic [WB_LANES-1:0] avail;
  logic [WB_LANES-1:0] uniq;

  always_comb begin
    avail = '0;
    uniq  = '1;
    for (int j = 0; j < WB_LANES; j++) begin
      avail[j] = (count > CW'(j));
      for (int k = 0; k < j; k++) begin
        if (addr[k] == addr[j]) begin
          uniq[j] = 1'b0;
        end
      end
    end
  end

  // Walk from the oldest slot; the first unavailable or repeated slot
  // closes the group, so every later slot is excluded too.
  logic go;

  always_comb begin
    en    = '0;
    n_deq = '0;
    go    = !hold;
    for (int j = 0; j < WB_LANES; j++) begin
      go    = go && avail[j] && uniq[j];
      en[j] = go;
      n_deq = n_deq + WB_NW'(go);
    end
  end

endmodule

// File: rtl/wb_buffer.sv
// -----------------------------------------------------------------------------
// wb_buffer
//   4-lane writeback buffer in front of the 4-write integer register file.
//   Up to four execution results per cycle are compacted into a FIFO; up to
//   four are drained per cycle onto the regfile write ports in program order,
//   never writing one register twice in the same cycle.
//
//   Build option: define WB_FWD_EN to add two forwarding search ports
//   (i_faddr0/1 -> o_fhit0/1, o_fdata0/1). Without it those ports and the
//   search logic do not exist.
//
//   Handshake: o_ready is a function of the registered occupancy only. An
//   enqueue happens at a rising edge where o_ready=1; every lane with
//   i_valid=1 is then taken at once. While o_ready=0 nothing is taken and the
//   producer keeps i_valid/i_addr*/i_data* stable until an edge with o_ready=1.
//   The regfile side has no back-pressure: every o_we* pulse is a completed
//   write, and i_hold=1 simply withholds the group for that cycle.
//
//   Ports:
//     i_clk, i_rst_n             clock (rising), async active-low reset
//     i_valid[3:0]               per-lane result valid (lane k = bit k)
//     i_addr0..3, i_data0..3     per-lane destination register and data
//     o_ready                    room for a full 4-lane beat
//     i_hold                     suppress draining this cycle
//     o_we0..3                   regfile write enables, port 0..3
//     o_waddr0..3, o_wdata0..3   regfile write address/data (0 when not enabled)
//     o_count, o_empty           occupancy and occupancy==0
//     i_faddr0/1, o_fhit0/1,
//     o_fdata0/1                 (WB_FWD_EN) youngest queued value for a register
// -----------------------------------------------------------------------------
module wb_buffer
  import wb_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int AW    = WB_AW,
  parameter  int DW    = WB_DW,
  localparam int PW    = wb_ptr_w(DEPTH),
  localparam int CW    = wb_cnt_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [3:0]    i_valid,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [AW-1:0] i_addr2,
  input  logic [AW-1:0] i_addr3,
  input  logic [DW-1:0] i_data0,
  input  logic [DW-1:0] i_data1,
  input  logic [DW-1:0] i_data2,
  input  logic [DW-1:0] i_data3,
  output logic          o_ready,
  input  logic          i_hold,
  output logic          o_we0,
  output logic          o_we1,
  output logic          o_we2,
  output logic          o_we3,
  output logic [AW-1:0] o_waddr0,
  output logic [AW-1:0] o_waddr1,
  output logic [AW-1:0] o_waddr2,
  output logic [AW-1:0] o_waddr3,
  output logic [DW-1:0] o_wdata0,
  output logic [DW-1:0] o_wdata1,
  output logic [DW-1:0] o_wdata2,
  output logic [DW-1:0] o_wdata3,
  output logic [CW-1:0] o_count,
`ifdef WB_FWD_EN
  input  logic [AW-1:0] i_faddr0,
  input  logic [AW-1:0] i_faddr1,
  output logic          o_fhit0,
  output logic          o_fhit1,
  output logic [DW-1:0] o_fdata0,
  output logic [DW-1:0] o_fdata1,
`endif
  output logic          o_empty
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  // Room for a worst-case 4-lane beat; independent of i_valid so the producer
  // never sees a combinational path back through this block.
  assign o_ready = (count_q <= CW'(DEPTH - WB_LANES));
  assign o_count = count_q;
  assign o_empty = (count_q == '0);

  // ---------------------------------------------------------------------------
  // Lane compaction
  // ---------------------------------------------------------------------------
  // Register 0 is never written, so those lanes are discarded here rather than
  // occupying a slot. Surviving lanes pack into tail, tail+1, ... in lane order.
  logic [AW-1:0]       lane_addr [WB_LANES];
  logic [DW-1:0]       lane_data [WB_LANES];
  logic [WB_LANES-1:0] lane_take;
  logic [PW-1:0]       lane_off  [WB_LANES];
  logic [WB_NW-1:0]    n_enq;

  assign lane_addr[0] = i_addr0;
  assign lane_addr[1] = i_addr1;
  assign lane_addr[2] = i_addr2;
  assign lane_addr[3] = i_addr3;
  assign lane_data[0] = i_data0;
  assign lane_data[1] = i_data1;
  assign lane_data[2] = i_data2;
  assign lane_data[3] = i_data3;

  always_comb begin
    n_enq     = '0;
    lane_take = '0;
    for (int k = 0; k < WB_LANES; k++) begin
      lane_take[k] = i_valid[k] && (lane_addr[k] != '0);
      lane_off[k]  = PW'(n_enq);
      n_enq        = n_enq + WB_NW'(lane_take[k]);
    end
  end

  // Entries actually added at the coming edge.
  logic [WB_NW-1:0] n_add;
  assign n_add = o_ready ? n_enq : '0;

  // ---------------------------------------------------------------------------
  // Drain group
  // ---------------------------------------------------------------------------
  // Peek window of the four oldest slots; pointer arithmetic wraps modulo
  // DEPTH, so a group may straddle the end of the array.
  logic [AW-1:0]       peek_addr [WB_LANES];
  logic [DW-1:0]       peek_data [WB_LANES];
  logic [WB_LANES-1:0] drain_en;
  logic [WB_NW-1:0]    n_deq;

  always_comb begin
    for (int j = 0; j < WB_LANES; j++) begin
      peek_addr[j] = mem_addr[head_q + PW'(j)];
      peek_data[j] = mem_data[head_q + PW'(j)];
    end
  end

  wb_drain_sel #(
    .AW (AW),
    .CW (CW)
  ) u_drain_sel (
    .addr  (peek_addr),
    .count (count_q),
    .hold  (i_hold),
    .en    (drain_en),
    .n_deq (n_deq)
  );

  // Address/data are forced to zero on idle ports so the regfile inputs are
  // quiet and deterministic after reset.
  assign o_we0    = drain_en[0];
  assign o_we1    = drain_en[1];
  assign o_we2    = drain_en[2];
  assign o_we3    = drain_en[3];
  assign o_waddr0 = drain_en[0] ? peek_addr[0] : '0;
  assign o_waddr1 = drain_en[1] ? peek_addr[1] : '0;
  assign o_waddr2 = drain_en[2] ? peek_addr[2] : '0;
  assign o_waddr3 = drain_en[3] ? peek_addr[3] : '0;
  assign o_wdata0 = drain_en[0] ? peek_data[0] : '0;
  assign o_wdata1 = drain_en[1] ? peek_data[1] : '0;
  assign o_wdata2 = drain_en[2] ? peek_data[2] : '0;
  assign o_wdata3 = drain_en[3] ? peek_data[3] : '0;

  // ---------------------------------------------------------------------------
  // Pointer and occupancy registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(n_deq);
      tail_q  <= tail_q + PW'(n_add);
      count_q <= count_q + CW'(n_add) - CW'(n_deq);
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && o_ready) begin
      for (int k = 0; k < WB_LANES; k++) begin
        if (lane_take[k]) begin
          mem_addr[tail_q + lane_off[k]] <= lane_addr[k];
          mem_data[tail_q + lane_off[k]] <= lane_data[k];
        end
      end
    end
  end

`ifdef WB_FWD_EN
  // ---------------------------------------------------------------------------
  // Forwarding search
  // ---------------------------------------------------------------------------
  // Scans live slots oldest to youngest so the last match wins, i.e. the
  // youngest value for the register. Slots draining this cycle are still live
  // in storage and therefore still hit.
  always_comb begin
    o_fhit0  = 1'b0;
    o_fhit1  = 1'b0;
    o_fdata0 = '0;
    o_fdata1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if ((i_faddr0 != '0) && (mem_addr[head_q + PW'(i)] == i_faddr0)) begin
          o_fhit0  = 1'b1;
          o_fdata0 = mem_data[head_q + PW'(i)];
        end
        if ((i_faddr1 != '0) && (mem_addr[head_q + PW'(i)] == i_faddr1)) begin
          o_fhit1  = 1'b1;
          o_fdata1 = mem_data[head_q + PW'(i)];
        end
      end
    end
  end
`endif

endmodule
